// File: rtl/button_conditioner.sv
// Pushbutton input conditioner feeding the processor's input bus buffer.
// Per bit: two-flop synchroniser, debounce counter, clean level, one-cycle
// rising-edge pulse and a sticky press flag cleared by the read strobe.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high
//   btn_raw    in   WIDTH  raw asynchronous button levels (1 = pressed)
//   rd_ack     in   1      input-read strobe; clears btn_event at the next edge
//   btn_level  out  WIDTH  debounced level
//   btn_rise   out  WIDTH  one-cycle pulse on an accepted 0->1 of btn_level
//   btn_event  out  WIDTH  sticky press flags
//   data_out   out  WIDTH  value for the input buffer (btn_event or btn_level)
module button_conditioner #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          STICKY          = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_event,
    output logic [WIDTH-1:0] data_out
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] event_next;

    // Per-bit debounce: count while the synchronised value differs from the
    // accepted level; any return to the level restarts the window from zero.
    always_comb begin
        accept = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Accepted bits take the synchronised value; only a 0->1 accept pulses.
    // A new rise overrides a simultaneous read clear so no press is lost.
    always_comb begin
        level_next = (btn_level & ~accept) | (sync2 & accept);
        rise_set   = accept & sync2;
        event_next = (btn_event & ~{WIDTH{rd_ack}}) | rise_set;
    end

    // Synchroniser, counters and conditioned outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            btn_level <= '0;
            btn_rise  <= '0;
            btn_event <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            btn_level <= level_next;
            btn_rise  <= rise_set;
            btn_event <= event_next;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Input-buffer view taken straight from registers, no added latency.
    assign data_out = STICKY ? btn_event : btn_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce window.
module tb_button_conditioner;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] btn_raw;
    logic             rd_ack;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_rise;
    logic [WIDTH-1:0] btn_event;
    logic [WIDTH-1:0] data_out;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] rise_seen;

    always #5 clk = ~clk;

    button_conditioner #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4),
        .STICKY          (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .rd_ack    (rd_ack),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_event (btn_event),
        .data_out  (data_out)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance n rising edges; sample 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rise_seen = rise_seen | btn_rise;
        end
    endtask

    task automatic read_pulse();
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        btn_raw   = '0;
        rd_ack    = 1'b0;
        rise_seen = '0;

        // Reset state
        step(2);
        check("rst_level", btn_level, 4'b0000);
        check("rst_rise",  btn_rise,  4'b0000);
        check("rst_event", btn_event, 4'b0000);
        check("rst_data",  data_out,  4'b0000);
        reset = 1'b0;
        step(2);
        check("idle_level", btn_level, 4'b0000);

        // Clean press on bit0: level at edge 6, one-cycle rise
        btn_raw = 4'b0001;
        step(5);
        check("press_e5_level", btn_level, 4'b0000);
        check("press_e5_rise",  btn_rise,  4'b0000);
        step(1);
        check("press_e6_level", btn_level, 4'b0001);
        check("press_e6_rise",  btn_rise,  4'b0001);
        check("press_e6_event", btn_event, 4'b0001);
        check("press_e6_data",  data_out,  4'b0001);
        step(1);
        check("press_e7_rise",  btn_rise,  4'b0000);
        check("press_e7_event", btn_event, 4'b0001);

        // Release: no pulse, sticky flag unchanged
        rise_seen = '0;
        btn_raw   = 4'b0000;
        step(5);
        check("rel_e5_level", btn_level, 4'b0001);
        step(1);
        check("rel_e6_level", btn_level, 4'b0000);
        check("rel_event",    btn_event, 4'b0001);
        check("rel_data",     data_out,  4'b0001);
        step(2);
        check("rel_no_rise",  rise_seen, 4'b0000);
        read_pulse();
        check("rel_clear",    btn_event, 4'b0000);

        // Glitch: three cycles high is one short of acceptance
        rise_seen = '0;
        btn_raw   = 4'b0001;
        step(3);
        btn_raw = 4'b0000;
        step(8);
        check("glitch_level", btn_level, 4'b0000);
        check("glitch_event", btn_event, 4'b0000);
        check("glitch_rise",  rise_seen, 4'b0000);

        // Read clear of 0101
        btn_raw = 4'b0101;
        step(6);
        check("rc_level", btn_level, 4'b0101);
        check("rc_event", btn_event, 4'b0101);
        btn_raw = 4'b0000;
        step(6);
        check("rc_rel_level", btn_level, 4'b0000);
        check("rc_rel_event", btn_event, 4'b0101);
        read_pulse();
        check("rc_cleared", btn_event, 4'b0000);

        // Read clear coinciding with bit2 accept: set wins
        btn_raw = 4'b0101;
        step(6);
        btn_raw = 4'b0000;
        step(6);
        check("rcs_pre_event", btn_event, 4'b0101);
        btn_raw = 4'b0100;
        step(5);
        check("rcs_e5_level", btn_level, 4'b0000);
        read_pulse();
        check("rcs_event", btn_event, 4'b0100);
        check("rcs_rise",  btn_rise,  4'b0100);
        check("rcs_level", btn_level, 4'b0100);

        // Reset mid-count on bit3: everything clears immediately
        btn_raw = 4'b1100;
        step(4);
        reset = 1'b1;
        #1;
        check("mr_level", btn_level, 4'b0000);
        check("mr_event", btn_event, 4'b0000);
        check("mr_rise",  btn_rise,  4'b0000);
        check("mr_data",  data_out,  4'b0000);
        step(2);
        reset = 1'b0;
        btn_raw = 4'b1000;
        step(5);
        check("mr_e5_level", btn_level, 4'b0000);
        step(1);
        check("mr_e6_level", btn_level, 4'b1000);
        check("mr_e6_rise",  btn_rise,  4'b1000);

        // Independent bits: bit1 then bit3 two cycles later
        btn_raw = 4'b0000;
        step(6);
        read_pulse();
        check("ind_pre_event", btn_event, 4'b0000);
        btn_raw = 4'b0010;
        step(2);
        btn_raw = 4'b1010;
        step(3);
        check("ind_e5_rise",  btn_rise,  4'b0000);
        step(1);
        check("ind_e6_rise",  btn_rise,  4'b0010);
        step(1);
        check("ind_e7_rise",  btn_rise,  4'b0000);
        step(1);
        check("ind_e8_rise",  btn_rise,  4'b1000);
        check("ind_e8_level", btn_level, 4'b1010);
        step(1);
        check("ind_e9_rise",  btn_rise,  4'b0000);
        check("ind_event",    btn_event, 4'b1010);
        check("ind_data",     data_out,  4'b1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
